// File: rtl/window_builder.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3-column shift
// register produce one packed 216-bit window per interior pixel of a raster frame.
module window_builder #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_frame_start,
    input  logic               i_pixel_valid,
    input  logic [23:0]        i_pixel_in,
    output logic [215:0]       o_window_data,
    output logic               o_window_valid,
    output logic [COORD_W-1:0] o_center_row,
    output logic [COORD_W-1:0] o_center_col,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int IDX_W = $clog2(IMG_WIDTH);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;
    logic [23:0]        r_lineBuf1 [IMG_WIDTH];
    logic [23:0]        r_lineBuf2 [IMG_WIDTH];
    logic [23:0]        r_win [9];
    logic [23:0]        w_newWin [9];
    logic [215:0]       w_packed;
    logic [COORD_W-1:0] w_row;
    logic [COORD_W-1:0] w_col;
    logic [IDX_W-1:0]   w_colIdx;
    logic               w_accept;
    logic               w_last;
    logic               w_emit;

    logic [215:0]       r_windowData;
    logic               r_windowValid;
    logic [COORD_W-1:0] r_centerRow;
    logic [COORD_W-1:0] r_centerCol;
    logic               r_busy;
    logic               r_frameDone;

    // frame_start restarts the coordinate space in the same cycle it arrives.
    always_comb begin
        w_row    = i_frame_start ? '0 : r_row;
        w_col    = i_frame_start ? '0 : r_col;
        w_colIdx = w_col[IDX_W-1:0];
        w_accept = i_pixel_valid && (i_frame_start || (r_state == ACTIVE));
        w_last   = w_accept && (w_row == LAST_ROW) && (w_col == LAST_COL);
        w_emit   = w_accept && (w_row >= COORD_W'(2)) && (w_col >= COORD_W'(2));
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_newWin[i] = '0;
        end
        for (int r = 0; r < 3; r++) begin
            w_newWin[3*r]     = r_win[3*r+1];
            w_newWin[3*r + 1] = r_win[3*r+2];
        end
        w_newWin[2] = r_lineBuf2[w_colIdx];
        w_newWin[5] = r_lineBuf1[w_colIdx];
        w_newWin[8] = i_pixel_in;
        w_packed = '0;
        for (int k = 0; k < 9; k++) begin
            w_packed[215 - 24*k -: 24] = w_newWin[k];
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = IDLE;
            ACTIVE:  w_nextState = ACTIVE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (i_frame_start) begin
            w_nextState = ACTIVE;
        end
        if (w_last) begin
            w_nextState = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Line buffers and the window shift register are pure datapath and keep contents across reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lineBuf2[w_colIdx] <= r_lineBuf1[w_colIdx];
            r_lineBuf1[w_colIdx] <= i_pixel_in;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= w_newWin[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_row         <= '0;
            r_col         <= '0;
            r_windowData  <= '0;
            r_windowValid <= 1'b0;
            r_centerRow   <= '0;
            r_centerCol   <= '0;
            r_busy        <= 1'b0;
            r_frameDone   <= 1'b0;
        end else begin
            r_busy        <= (w_nextState == ACTIVE);
            r_frameDone   <= (w_nextState == DONE);
            r_windowValid <= w_emit;
            if (w_accept) begin
                if (w_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (w_col == LAST_COL) begin
                    r_row <= w_row + COORD_W'(1);
                    r_col <= '0;
                end else begin
                    r_row <= w_row;
                    r_col <= w_col + COORD_W'(1);
                end
            end else if (i_frame_start) begin
                r_row <= '0;
                r_col <= '0;
            end
            if (w_emit) begin
                r_windowData <= w_packed;
                r_centerRow  <= w_row - COORD_W'(1);
                r_centerCol  <= w_col - COORD_W'(1);
            end
        end
    end

    assign o_window_data  = r_windowData;
    assign o_window_valid = r_windowValid;
    assign o_center_row   = r_centerRow;
    assign o_center_col   = r_centerCol;
    assign o_busy         = r_busy;
    assign o_frame_done   = r_frameDone;

endmodule

// File: tb/tb_window_builder.sv
// Scoreboard bench for window_builder on a 4x4 frame where pixel (r,c) = {r, c, 8'h5A}.
module tb_window_builder;

    localparam int W = 4;
    localparam int H = 4;
    localparam int CW = 10;

    typedef struct {
        logic [215:0]  data;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          nRst;
    logic          frameStart;
    logic          pixelValid;
    logic [23:0]   pixelIn;
    logic [215:0]  windowData;
    logic          windowValid;
    logic [CW-1:0] centerRow;
    logic [CW-1:0] centerCol;
    logic          busy;
    logic          frameDone;

    exp_t          sbQ[$];
    exp_t          lastExp;
    int            checks = 0;
    int            errors = 0;
    int            cycleCount = 0;
    logic          monEn = 1'b0;
    logic          expBusy = 1'b0;
    logic          expDone = 1'b0;
    int            winSeen = 0;
    int            doneSeen = 0;
    logic [215:0]  obsFirst;
    logic [215:0]  obsLast;
    logic [CW-1:0] obsLastRow;
    logic [CW-1:0] obsLastCol;

    window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
        .clk            (clk),
        .n_rst          (nRst),
        .i_frame_start  (frameStart),
        .i_pixel_valid  (pixelValid),
        .i_pixel_in     (pixelIn),
        .o_window_data  (windowData),
        .o_window_valid (windowValid),
        .o_center_row   (centerRow),
        .o_center_col   (centerCol),
        .o_busy         (busy),
        .o_frame_done   (frameDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int r, input int c);
        logic [7:0] rb;
        logic [7:0] cb;
        rb = 8'(r);
        cb = 8'(c);
        return {rb, cb, 8'h5A};
    endfunction

    // Inputs change #1 after an edge; the bench's busy/done model advances on the same edge as the DUT.
    task automatic applyStimulus(input logic fs, input logic pv, input logic [23:0] p, input logic last);
        frameStart = fs;
        pixelValid = pv;
        pixelIn    = p;
        @(posedge clk);
        if (fs) expBusy = 1'b1;
        if (last) expBusy = 1'b0;
        expDone = last;
        #1;
        frameStart = 1'b0;
        pixelValid = 1'b0;
    endtask

    task automatic sendFrame(input int rOff, input bit gap, input int nPix);
        exp_t e;
        for (int idx = 0; idx < nPix; idx++) begin
            int r;
            int c;
            r = idx / W;
            c = idx % W;
            if (r >= 2 && c >= 2) begin
                e.data = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        e.data[215 - 24*(3*i + j) -: 24] = pix(r - 2 + i + rOff, c - 2 + j);
                    end
                end
                e.row = CW'(r - 1);
                e.col = CW'(c - 1);
                e.cyc = cycleCount + 1;
                sbQ.push_back(e);
            end
            applyStimulus(idx == 0, 1'b1, pix(r + rOff, c), (r == H - 1) && (c == W - 1));
            if (gap) applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        end
    endtask

    task automatic settle();
        repeat (3) applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        checkOutput("pendingWindows", 216'(sbQ.size()), 216'(0));
    endtask

    // Every cycle: windows are popped against the scoreboard, idle cycles must hold the last window.
    always @(negedge clk) begin
        exp_t e;
        if (monEn) begin
            checkOutput("busy", 216'(busy), 216'(expBusy));
            checkOutput("frameDone", 216'(frameDone), 216'(expDone));
            if (frameDone) doneSeen++;
            if (windowValid) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedWindow", 216'(1), 216'(0));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("windowData", windowData, e.data);
                    checkOutput("centerRow", 216'(centerRow), 216'(e.row));
                    checkOutput("centerCol", 216'(centerCol), 216'(e.col));
                    checkOutput("latency", 216'(cycleCount), 216'(e.cyc));
                    lastExp = e;
                end
                if (winSeen == 0) obsFirst = windowData;
                obsLast    = windowData;
                obsLastRow = centerRow;
                obsLastCol = centerCol;
                winSeen++;
            end else begin
                checkOutput("holdData", windowData, lastExp.data);
                checkOutput("holdCenter", 216'({centerRow, centerCol}), 216'({lastExp.row, lastExp.col}));
            end
        end
    end

    initial begin
        int d0;
        lastExp.data = '0;
        lastExp.row  = '0;
        lastExp.col  = '0;
        lastExp.cyc  = 0;
        nRst = 1'b0;
        frameStart = 1'b0;
        pixelValid = 1'b0;
        pixelIn = 24'h0;
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
        checkOutput("rstValid", 216'(windowValid), 216'(0));
        checkOutput("rstData", windowData, 216'(0));
        checkOutput("rstBusy", 216'(busy), 216'(0));
        checkOutput("rstDone", 216'(frameDone), 216'(0));
        monEn = 1'b1;

        $display("[TB] continuous frame");
        winSeen = 0;
        d0 = doneSeen;
        sendFrame(0, 1'b0, W * H);
        settle();
        checkOutput("contWinCount", 216'(winSeen), 216'(4));
        checkOutput("contDoneCount", 216'(doneSeen - d0), 216'(1));
        checkOutput("firstK0", 216'(obsFirst[215:192]), 216'(24'h00005A));
        checkOutput("firstK4", 216'(obsFirst[119:96]), 216'(24'h01015A));
        checkOutput("firstK8", 216'(obsFirst[23:0]), 216'(24'h02025A));
        checkOutput("lastK8", 216'(obsLast[23:0]), 216'(24'h03035A));
        checkOutput("lastCenter", 216'({obsLastRow, obsLastCol}), 216'({10'd2, 10'd2}));

        $display("[TB] gapped frame");
        winSeen = 0;
        d0 = doneSeen;
        sendFrame(0, 1'b1, W * H);
        settle();
        checkOutput("gapWinCount", 216'(winSeen), 216'(4));
        checkOutput("gapDoneCount", 216'(doneSeen - d0), 216'(1));

        $display("[TB] stray pixels in idle");
        winSeen = 0;
        repeat (3) applyStimulus(1'b0, 1'b1, pix(1, 1), 1'b0);
        settle();
        checkOutput("strayWinCount", 216'(winSeen), 216'(0));

        $display("[TB] abort then frame B");
        winSeen = 0;
        d0 = doneSeen;
        sendFrame(0, 1'b0, 9);
        sendFrame(8, 1'b0, W * H);
        settle();
        checkOutput("abortWinCount", 216'(winSeen), 216'(4));
        checkOutput("abortDoneCount", 216'(doneSeen - d0), 216'(1));
        checkOutput("abortFirstK0", 216'(obsFirst[215:192]), 216'(24'h08005A));

        $display("[TB] reset mid-stream");
        winSeen = 0;
        d0 = doneSeen;
        sendFrame(0, 1'b0, 11);
        nRst = 1'b0;
        frameStart = 1'b0;
        pixelValid = 1'b1;
        pixelIn = pix(2, 3);
        @(posedge clk);
        expBusy = 1'b0;
        expDone = 1'b0;
        lastExp.data = '0;
        lastExp.row  = '0;
        lastExp.col  = '0;
        #1;
        nRst = 1'b1;
        pixelValid = 1'b0;
        checkOutput("midRstValid", 216'(windowValid), 216'(0));
        checkOutput("midRstData", windowData, 216'(0));
        checkOutput("midRstCenter", 216'({centerRow, centerCol}), 216'(0));
        checkOutput("midRstBusy", 216'(busy), 216'(0));
        applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        sendFrame(0, 1'b0, W * H);
        settle();
        checkOutput("rstWinCount", 216'(winSeen), 216'(5));
        checkOutput("rstDoneCount", 216'(doneSeen - d0), 216'(1));

        $display("[TB] back-to-back frames");
        winSeen = 0;
        d0 = doneSeen;
        sendFrame(0, 1'b0, W * H);
        sendFrame(4, 1'b0, W * H);
        settle();
        checkOutput("b2bWinCount", 216'(winSeen), 216'(8));
        checkOutput("b2bDoneCount", 216'(doneSeen - d0), 216'(2));

        monEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_builder.md
Name: window_builder

Overview:
- Streaming 3x3 neighbourhood generator for the cartoonify filter path; the producer side of the 216-bit pixelData window consumed by the mean-average/edge stages.
- Accepts one raster-order 24-bit RGB pixel per valid cycle and stores the two previous image rows in line buffers.
- Emits one packed 3x3 window for every interior pixel of the frame.

Parameters:
- IMG_WIDTH, 640, pixels per row (>=3)
- IMG_HEIGHT, 480, rows per frame (>=3)
- COORD_W, 10, width of row/column counters and coordinate outputs; must hold max(IMG_WIDTH, IMG_HEIGHT)-1

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous reset, active-low
- frame_start  in  1  pulse: start a new frame; pixel_in in the same cycle (if valid) is pixel (0,0)
- pixel_valid  in  1  pixel_in is valid this cycle
- pixel_in  in  24  {R[23:16], G[15:8], B[7:0]}
- window_data  out  216  packed 3x3 window, registered
- window_valid  out  1  window_data valid, one-cycle pulse per window
- center_row  out  COORD_W  row of the window centre pixel
- center_col  out  COORD_W  column of the window centre pixel
- busy  out  1  high in ACTIVE
- frame_done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (n_rst=0 at clk edge):
  - State goes to IDLE; all outputs 0; row/col counters 0.
  - Line buffer RAM contents are not cleared.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE: frame_start -> ACTIVE. pixel_valid without frame_start is ignored.
  - ACTIVE: accepts pixels. Acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE.
  - DONE: lasts one cycle with frame_done=1, then -> IDLE. frame_start in DONE -> ACTIVE; frame_done still pulses.
- frame_start in any state:
  - Counters are forced to (0,0) and state to ACTIVE.
  - If pixel_valid is also high, that pixel is accepted as (0,0).
  - In ACTIVE this aborts the current frame; the aborted frame gets no frame_done.
- Pixel acceptance: ACTIVE (or frame_start cycle) and pixel_valid=1. There is no backpressure; the consumer is always ready.
- On accepting pixel P at (row, col):
  - Column shift: the 3x3 register shifts left by one column.
  - New right column is {top=linebuf2[col], mid=linebuf1[col], bottom=P}.
  - Line buffers: linebuf2[col] <= linebuf1[col]; linebuf1[col] <= P.
  - Counters: col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
- Window emission: if row>=2 and col>=2 at acceptance, then on the next cycle:
  - window_valid=1 and window_data holds the updated 3x3.
  - center_row=row-1, center_col=col-1.
  - Latency is exactly 1 cycle from accepting clk edge to output.
  - Border pixels produce no window: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per complete frame.
- Packing is row-major, pixel k at window_data[215-24k -: 24]:
  - k=0 top-left, k=4 centre, k=8 bottom-right.
  - Each pixel is R,G,B MSB-first.
  - Matches the consumer's r0=[215:208] ... b8=[7:0] layout.
- Stale columns: at col 0 and 1 the shift register holds previous-row data. This is harmless because no window is emitted there.
- Gaps in pixel_valid:
  - Counters and window are held.
  - window_valid is 0; window_data, center_row and center_col hold their last values.
- Outputs are registered. window_valid and frame_done are never high outside their defined cycles.

Test Plan:
Setup: IMG_WIDTH=4, IMG_HEIGHT=4, pixel (r,c) = {r[7:0], c[7:0], 8'h5A}.
- Continuous frame, pixel_valid=1 for 16 cycles after frame_start:
  - Exactly 4 window_valid pulses, the first 1 cycle after pixel (2,2).
  - First window: window_data[215:192]=24'h00005A, [119:96]=24'h01015A, [23:0]=24'h02025A; center=(1,1).
  - Last window: center=(2,2), k8=24'h03035A.
  - frame_done pulses 1 cycle after pixel (3,3).
- Same frame with pixel_valid toggled 1,0,1,0,...:
  - Identical window contents and order.
  - No window_valid in gap cycles; outputs hold between windows.
- Stray input: pixel_valid=1 in IDLE with no frame_start -> no counter change, busy=0, no windows.
- Abort: frame_start asserted at pixel (2,1) of frame A, then full frame B with r offset +8:
  - Frame A produces no frame_done.
  - Frame B produces exactly 4 windows, all of B's data, e.g. first k0=24'h08005A.
- Reset mid-stream: n_rst=0 for 1 cycle at pixel (2,3):
  - Next cycle all outputs are 0 and state is IDLE.
  - A following frame produces 4 correct windows.
- Back-to-back frames: frame_start coincident with frame_done cycle -> 4 windows per frame; frame_done pulses once per frame.
